// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers and default geometry for the width-converting FIFO
package sync_fifo_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max_w(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int min_w(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
  localparam int DEF_DIN_WIDTH = 256;
  localparam int DEF_DOUT_WIDTH = 64;
  localparam int DEF_DEPTH = 16;
  localparam int WIDE = max_w(DEF_DIN_WIDTH, DEF_DOUT_WIDTH);
  localparam int NARROW = min_w(DEF_DIN_WIDTH, DEF_DOUT_WIDTH);
  localparam int RATIO = WIDE / NARROW;
  localparam int IDX_W = RATIO > 1 ? clog2(RATIO) : 1;
  localparam int CNT_W = clog2(DEF_DEPTH + 1);
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FWFT FIFO of W-bit entries with occupancy count
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int W     = 256,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [W-1:0]                din,
  input  logic                        rd_en,
  output logic [W-1:0]                dout,
  output logic                        full,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
endmodule

// File: rtl/sync_width_conv_fifo.sv
// sync_width_conv_fifo: FWFT FIFO converting DIN_WIDTH writes to DOUT_WIDTH reads,
// storing max-width entries and packing/slicing narrow words little-endian.
module sync_width_conv_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DIN_WIDTH    = 256,
  parameter int DOUT_WIDTH   = 64,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DIN_WIDTH-1:0]        din,
  input  logic                        rd_en,
  output logic [DOUT_WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int WW = max_w(DIN_WIDTH, DOUT_WIDTH);
  localparam int NW = min_w(DIN_WIDTH, DOUT_WIDTH);
  localparam int RW = WW / NW;
  localparam int IW = RW > 1 ? clog2(RW) : 1;
  localparam int CW = clog2(DEPTH + 1);
  if (WW % NW != 0 || !is_pow2(RW) || !is_pow2(DEPTH) || DEPTH < 2 ||
      AEMPTY_LEVEL >= AFULL_LEVEL || AFULL_LEVEL > DEPTH) begin : g_bad_cfg
    $error("sync_width_conv_fifo: illegal parameter set");
  end
  logic core_wr, core_rd;
  logic [WW-1:0] core_din, head;
  sync_fifo_core #(.W(WW), .DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .wr_en (core_wr),
    .din   (core_din),
    .rd_en (core_rd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  if (DIN_WIDTH >= DOUT_WIDTH) begin : g_down
    logic [IW-1:0] s;
    logic last;
    assign last     = s == IW'(RW - 1);
    assign core_wr  = wr_en;
    assign core_din = din;
    assign core_rd  = rd_en && last;
    assign dout     = head[int'(s) * DOUT_WIDTH +: DOUT_WIDTH];
    always_ff @(posedge clk)
      if (rst) s <= '0;
      else if (rd_en && !empty) s <= last ? '0 : s + 1'b1;
  end else begin : g_up
    logic [IW-1:0] p;
    logic [WW-NW-1:0] pack;
    logic take, last;
    assign take     = wr_en && !full;
    assign last     = p == IW'(RW - 1);
    // the final slot bypasses the pack register straight into storage
    assign core_wr  = take && last;
    assign core_din = {din, pack};
    assign core_rd  = rd_en;
    assign dout     = head;
    always_ff @(posedge clk)
      if (rst) p <= '0;
      else if (take) p <= last ? '0 : p + 1'b1;
    always_ff @(posedge clk)
      if (take && !last) pack[int'(p) * NW +: NW] <= din;
  end
  assign almost_full  = count >= CW'(AFULL_LEVEL);
  assign almost_empty = count <= CW'(AEMPTY_LEVEL);
  always_ff @(posedge clk)
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// tb_sync_width_conv_fifo: vector table on a 256->64 instance, hand sequences on a 64->256 instance
module tb_sync_width_conv_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic d_wr, d_rd, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
  logic [255:0] d_din;
  logic [63:0]  d_dout;
  logic [4:0]   d_cnt;
  logic u_wr, u_rd, u_full, u_empty, u_af, u_ae, u_ovf, u_unf;
  logic [63:0]  u_din;
  logic [255:0] u_dout;
  logic [4:0]   u_cnt;

  sync_width_conv_fifo dut_down (
    .clk(clk), .rst(rst), .wr_en(d_wr), .din(d_din), .rd_en(d_rd), .dout(d_dout),
    .full(d_full), .empty(d_empty), .almost_full(d_af), .almost_empty(d_ae),
    .count(d_cnt), .overflow(d_ovf), .underflow(d_unf));

  sync_width_conv_fifo #(.DIN_WIDTH(64), .DOUT_WIDTH(256)) dut_up (
    .clk(clk), .rst(rst), .wr_en(u_wr), .din(u_din), .rd_en(u_rd), .dout(u_dout),
    .full(u_full), .empty(u_empty), .almost_full(u_af), .almost_empty(u_ae),
    .count(u_cnt), .overflow(u_ovf), .underflow(u_unf));

  typedef struct {
    bit           wr;
    logic [255:0] din;
    bit           rd;
    int           cnt;
    bit           ovf;
    bit           unf;
  } vec_t;

  vec_t         tbl[$];
  logic [63:0]  sb_d[$];
  logic [255:0] sb_u[$];
  int n_cmp = 0, n_bad = 0;
  int g_cnt = 0, g_s = 0;
  bit g_ovf = 0, g_unf = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] slice(input int k, input int j);
    return {8'(k), 56'h0} ^ {16{4'(j + 1)}};
  endfunction

  function automatic logic [255:0] word(input int k);
    logic [255:0] w;
    for (int j = 0; j < 4; j++) w[j*64 +: 64] = slice(k, j);
    return w;
  endfunction

  function automatic logic [63:0] nw(input int k);
    return {32'(k) ^ 32'hA5A5_0000, 32'(k * 7 + 1)};
  endfunction

  // expected state after one cycle of the 256->64 FIFO, appended as a table row
  task automatic add(input bit wr, input logic [255:0] din, input bit rd);
    bit f, e;
    f = g_cnt == 16;
    e = g_cnt == 0;
    if (wr && f) g_ovf = 1;
    if (rd && e) g_unf = 1;
    if (rd && !e) begin
      if (g_s == 3) begin
        g_s = 0;
        g_cnt--;
      end else g_s++;
    end
    if (wr && !f) g_cnt++;
    tbl.push_back('{wr, din, rd, g_cnt, g_ovf, g_unf});
  endtask

  task automatic up_wr(input logic [63:0] d);
    u_wr = 1; u_din = d;
    @(posedge clk); #1;
    u_wr = 0;
  endtask

  task automatic up_rd();
    u_rd = 1;
    @(posedge clk); #1;
    u_rd = 0;
  endtask

  task automatic chk_up_reset(input string tag);
    chk({tag, "_empty"}, u_empty, 1);
    chk({tag, "_aempty"}, u_ae, 1);
    chk({tag, "_full"}, u_full, 0);
    chk({tag, "_afull"}, u_af, 0);
    chk({tag, "_count"}, u_cnt, 0);
    chk({tag, "_ovf"}, u_ovf, 0);
    chk({tag, "_unf"}, u_unf, 0);
    chk({tag, "_dout"}, u_dout, 0);
  endtask

  initial begin
    bit pf, pe;
    logic [255:0] w;
    rst = 1; d_wr = 0; d_rd = 0; d_din = '0; u_wr = 0; u_rd = 0; u_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("dn_rst_empty", d_empty, 1);
    chk("dn_rst_aempty", d_ae, 1);
    chk("dn_rst_full", d_full, 0);
    chk("dn_rst_afull", d_af, 0);
    chk("dn_rst_count", d_cnt, 0);
    chk("dn_rst_ovf", d_ovf, 0);
    chk("dn_rst_unf", d_unf, 0);
    chk("dn_rst_dout", d_dout, 0);
    chk_up_reset("up_rst");
    rst = 0;

    add(1, word(0), 0);
    repeat (4) add(0, '0, 1);
    add(0, '0, 1);
    add(1, word(1), 1);
    repeat (4) add(0, '0, 1);
    for (int k = 2; k < 18; k++) add(1, word(k), 0);
    repeat (3) add(0, '0, 1);
    add(1, word(90), 1);
    add(1, word(18), 0);
    add(1, word(91), 0);
    repeat (64) add(0, '0, 1);
    for (int k = 20; k < 28; k++) add(1, word(k), 0);
    repeat (3) add(0, '0, 1);
    add(1, word(28), 1);
    repeat (32) add(0, '0, 1);

    pf = 0; pe = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      d_wr = tbl[i].wr; d_din = tbl[i].din; d_rd = tbl[i].rd;
      if (tbl[i].wr && !pf)
        for (int j = 0; j < 4; j++) sb_d.push_back(tbl[i].din[j*64 +: 64]);
      if (tbl[i].rd) begin
        if (pe) chk("dn_dout_empty", d_dout, 0);
        else chk("dn_dout", d_dout, sb_d.pop_front());
      end
      @(posedge clk); #1;
      chk("dn_count", d_cnt, 256'(tbl[i].cnt));
      chk("dn_empty", d_empty, tbl[i].cnt == 0);
      chk("dn_full", d_full, tbl[i].cnt == 16);
      chk("dn_afull", d_af, tbl[i].cnt >= 15);
      chk("dn_aempty", d_ae, tbl[i].cnt <= 1);
      chk("dn_ovf", d_ovf, tbl[i].ovf);
      chk("dn_unf", d_unf, tbl[i].unf);
      pf = tbl[i].cnt == 16;
      pe = tbl[i].cnt == 0;
    end
    d_wr = 0; d_rd = 0;
    chk("dn_sb_drained", 256'(sb_d.size()), 0);

    for (int j = 0; j < 4; j++) begin
      w[j*64 +: 64] = nw(j);
      up_wr(nw(j));
      chk("up_pack_count", u_cnt, j == 3 ? 1 : 0);
      chk("up_pack_empty", u_empty, j != 3);
    end
    chk("up_pack_dout", u_dout, w);
    up_rd();
    chk("up_drain_empty", u_empty, 1);
    chk("up_drain_dout", u_dout, 0);
    up_rd();
    chk("up_underflow", u_unf, 1);
    up_wr(nw(10));
    up_wr(nw(11));
    chk("up_partial_count", u_cnt, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_up_reset("up_midrst");
    for (int j = 0; j < 4; j++) begin
      w[j*64 +: 64] = nw(20 + j);
      up_wr(nw(20 + j));
    end
    sb_u.push_back(w);
    chk("up_fresh_count", u_cnt, 1);
    chk("up_fresh_dout", u_dout, w);
    for (int k = 0; k < 15; k++) begin
      for (int j = 0; j < 4; j++) begin
        w[j*64 +: 64] = nw(100 + 4 * k + j);
        up_wr(nw(100 + 4 * k + j));
      end
      sb_u.push_back(w);
    end
    chk("up_fill_count", u_cnt, 16);
    chk("up_fill_full", u_full, 1);
    chk("up_fill_afull", u_af, 1);
    chk("up_fill_ovf", u_ovf, 0);
    up_wr(nw(999));
    chk("up_refused_ovf", u_ovf, 1);
    chk("up_refused_count", u_cnt, 16);
    for (int k = 0; k < 16; k++) begin
      chk("up_fill_dout", u_dout, sb_u.pop_front());
      up_rd();
    end
    chk("up_fill_empty", u_empty, 1);
    for (int j = 0; j < 4; j++) begin
      w[j*64 +: 64] = nw(200 + j);
      up_wr(nw(200 + j));
    end
    chk("up_after_full_dout", u_dout, w);
    chk("up_after_full_count", u_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
